// File: rtl/ss_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ss_scan_ctrl
//
// Multiplexed seven-segment display controller. It captures a packed hex value
// from the core and scans it across NUM_DIGITS common-anode digits, one digit
// per slot. Each slot lasts 2^REFRESH_LOG2 clock cycles.
//
// Features:
//   - Tear-free update: new values wait in a pending register and move to the
//     display register only at the frame boundary.
//   - Optional leading-zero blanking.
//   - Per-digit decimal points.
//   - PWM brightness control.
//   - One dark cycle at the start of each slot, so the previous digit's
//     segments do not ghost onto the next anode.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous reset, active-low
//   value_i       packed hex nibbles; nibble i drives digit i (digit 0 = LSN)
//   load_i        capture value_i/dp_mask_i into the pending registers
//   dp_mask_i     decimal point per digit, 1 = lit
//   blank_lz_i    1 = blank leading-zero digits (digit 0 is never blanked)
//   enable_i      0 = all anodes off; scanning keeps running
//   brightness_i  PWM duty; 0 = dark, all-ones = full on
//   ss_sel_o      anode selects, active-low
//   seg_o         segments {g,f,e,d,c,b,a}, active-low
//   dp_o          decimal point, active-low
//   digit_idx_o   current scan slot
//   frame_tick_o  one-cycle pulse when digit_idx_o wraps to 0
// ---------------------------------------------------------------------------
module ss_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_LOG2 = 17,
  parameter int unsigned BRIGHT_W     = 4,
  localparam int unsigned IdxW        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic                    blank_lz_i,
  input  logic                    enable_i,
  input  logic [BRIGHT_W-1:0]     brightness_i,
  output logic [NUM_DIGITS-1:0]   ss_sel_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [IdxW-1:0]         digit_idx_o,
  output logic                    frame_tick_o
);

  // -------------------------------------------------------------------------
  // Scan timing
  // -------------------------------------------------------------------------
  logic [REFRESH_LOG2-1:0] presc_q, presc_d;
  logic [IdxW-1:0]         digit_idx_q, digit_idx_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    term_cnt;
  logic                    last_digit;
  logic                    frame_wrap;

  assign term_cnt   = &presc_q;
  assign last_digit = (digit_idx_q == IdxW'(NUM_DIGITS - 1));
  assign frame_wrap = term_cnt & last_digit;

  always_comb begin
    presc_d      = presc_q + 1'b1;
    digit_idx_d  = digit_idx_q;
    frame_tick_d = frame_wrap;
    if (term_cnt) begin
      // An explicit wrap is needed when NUM_DIGITS is not a power of two.
      digit_idx_d = last_digit ? '0 : digit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q      <= '0;
      digit_idx_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_idx_q  <= digit_idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // -------------------------------------------------------------------------
  // Capture: pending -> display at the frame boundary
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
      if (load_i) begin
        // A load on the boundary cycle bypasses pending and shows in the new frame.
        pend_val_d = value_i;
        pend_dp_d  = dp_mask_i;
        disp_val_d = value_i;
        disp_dp_d  = dp_mask_i;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (load_i) begin
      pend_val_d   = value_i;
      pend_dp_d    = dp_mask_i;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero detection
  // -------------------------------------------------------------------------
  // lz_blank[i] is set when nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is
  // never marked, so a zero value still shows a single "0".
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;

  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run    = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run & (i != 0);
    end
  end

  // -------------------------------------------------------------------------
  // Current digit select
  // -------------------------------------------------------------------------
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_lz;

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IdxW'(i)) begin
        cur_nib = disp_val_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
        cur_lz  = lz_blank[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Anode on-condition
  // -------------------------------------------------------------------------
  logic pwm_on;
  logic digit_on;

  // The top BRIGHT_W prescaler bits form the PWM ramp; all-ones brightness
  // forces full on, since the ramp can never compare below it.
  assign pwm_on = (&brightness_i) |
                  (presc_q[REFRESH_LOG2-1 -: BRIGHT_W] < brightness_i);

  // Prescaler 0 is the anti-ghost gap at the start of every slot.
  assign digit_on = enable_i & ~(blank_lz_i & cur_lz) &
                    (presc_q != '0) & pwm_on;

  // -------------------------------------------------------------------------
  // Hex to seven-segment, active-low {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] ss_sel_q, ss_sel_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  always_comb begin
    ss_sel_d = '1;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    if (digit_on) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        ss_sel_d[i] = (digit_idx_q != IdxW'(i));
      end
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ss_sel_q <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      ss_sel_q <= ss_sel_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign ss_sel_o     = ss_sel_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign digit_idx_o  = digit_idx_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ss_scan_ctrl
//
// Scoreboard bench for ss_scan_ctrl (4 digits, 16-cycle slots, 2-bit brightness).
// A reference model derives slot and prescaler from a cycle count and pushes
// the expected registered outputs each clock. A monitor pops them on the
// falling edge and compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_ss_scan_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned RL = 4;
  localparam int unsigned BW = 2;
  localparam int SLOT  = 1 << RL;
  localparam int FRAME = SLOT * N;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [4*N-1:0]  value_i;
  logic            load_i;
  logic [N-1:0]    dp_mask_i;
  logic            blank_lz_i;
  logic            enable_i;
  logic [BW-1:0]   brightness_i;
  logic [N-1:0]    ss_sel_o;
  logic [6:0]      seg_o;
  logic            dp_o;
  logic [1:0]      digit_idx_o;
  logic            frame_tick_o;

  ss_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_LOG2(RL),
    .BRIGHT_W    (BW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .value_i     (value_i),
    .load_i      (load_i),
    .dp_mask_i   (dp_mask_i),
    .blank_lz_i  (blank_lz_i),
    .enable_i    (enable_i),
    .brightness_i(brightness_i),
    .ss_sel_o    (ss_sel_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .digit_idx_o (digit_idx_o),
    .frame_tick_o(frame_tick_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N-1:0] sel;
    logic [6:0]   seg;
    logic         dp;
    logic [1:0]   idx;
    logic         ft;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_sel"}, int'(ss_sel_o), 'hF);
    chk({tag, "_seg"}, int'(seg_o), 'h7F);
    chk({tag, "_dp"}, int'(dp_o), 1);
    chk({tag, "_idx"}, int'(digit_idx_o), 0);
    chk({tag, "_ft"}, int'(frame_tick_o), 0);
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int           m_cyc;
  logic [15:0]  m_pend, m_disp;
  logic [N-1:0] m_pdp, m_ddp;
  bit           m_pv;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        m_cyc = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_pv = 0;
        exp_q.delete();
      end else begin
        int   presc, slot, nib;
        bit   wrap, blanked, pwm, on;
        exp_t e;
        presc   = m_cyc % SLOT;
        slot    = (m_cyc / SLOT) % N;
        wrap    = (presc == SLOT - 1) && (slot == N - 1);
        nib     = int'((m_disp >> (4 * slot)) & 16'hF);
        blanked = blank_lz_i && slot != 0 && ((m_disp >> (4 * slot)) == 16'h0);
        pwm     = (brightness_i == 2'd3) || ((presc / (SLOT / 4)) < int'(brightness_i));
        on      = enable_i && !blanked && presc != 0 && pwm;
        e.sel   = on ? ~(4'b0001 << slot) : 4'hF;
        e.seg   = on ? seg_tab[nib] : 7'h7F;
        e.dp    = on ? ~m_ddp[slot] : 1'b1;
        e.idx   = 2'(((m_cyc + 1) / SLOT) % N);
        e.ft    = wrap;
        exp_q.push_back(e);
        if (wrap) begin
          if (load_i) begin
            m_disp = value_i; m_ddp = dp_mask_i; m_pend = value_i; m_pdp = dp_mask_i;
          end else if (m_pv) begin
            m_disp = m_pend; m_ddp = m_pdp;
          end
          m_pv = 0;
        end else if (load_i) begin
          m_pend = value_i; m_pdp = dp_mask_i; m_pv = 1;
        end
        m_cyc++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk_off("rst");
      end else if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ss_sel", int'(ss_sel_o), int'(e.sel));
        chk("seg", int'(seg_o), int'(e.seg));
        chk("dp", int'(dp_o), int'(e.dp));
        chk("digit_idx", int'(digit_idx_o), int'(e.idx));
        chk("frame_tick", int'(frame_tick_o), int'(e.ft));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [15:0] v, input logic [N-1:0] m);
    value_i = v; dp_mask_i = m; load_i = 1'b1;
    step(1);
    load_i = 1'b0;
  endtask

  // Advance until the next cycle to be sampled has the given frame phase.
  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while ((m_cyc % FRAME) != ph && k < 2 * FRAME) begin
      step(1);
      k++;
    end
    if ((m_cyc % FRAME) != ph) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_phase: got %0d, expected %0d", m_cyc % FRAME, ph);
    end
  endtask

  initial begin
    rst_ni = 1'b0; value_i = '0; load_i = 1'b0; dp_mask_i = '0;
    blank_lz_i = 1'b0; enable_i = 1'b0; brightness_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #2 rst_ni = 1'b1;
    step(2);

    // Basic display with decimal point on digit 2
    enable_i = 1'b1; brightness_i = 2'd3;
    load(16'h12AF, 4'b0100);
    step(2 * FRAME);

    // Leading-zero blanking
    blank_lz_i = 1'b1;
    load(16'h00F0, 4'b0000);
    step(2 * FRAME);
    load(16'h0000, 4'b1000);
    step(2 * FRAME);
    load(16'h0305, 4'b0011);
    step(2 * FRAME);

    // Brightness sweep
    for (int b = 0; b < 4; b++) begin
      brightness_i = 2'(b);
      step(FRAME + 7);
    end

    // Last-load-wins before the boundary, then a load on the terminal cycle
    blank_lz_i = 1'b0;
    wait_phase(20);
    load(16'h1111, 4'b0001);
    wait_phase(40);
    load(16'h2222, 4'b0010);
    step(FRAME + 5);
    wait_phase(FRAME - 1);
    load(16'h5A3C, 4'b1001);
    step(FRAME + 3);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15) == 0) begin
        value_i   = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
        dp_mask_i = 4'($urandom);
        load_i    = 1'b1;
      end else begin
        load_i = 1'b0;
      end
      if ($urandom_range(63) == 0) enable_i = ~enable_i;
      if ($urandom_range(31) == 0) brightness_i = 2'($urandom);
      if ($urandom_range(31) == 0) blank_lz_i = ~blank_lz_i;
      step(1);
    end
    load_i = 1'b0; enable_i = 1'b1; brightness_i = 2'd3; blank_lz_i = 1'b0;
    load(16'h9876, 4'b1111);
    step(2 * FRAME);

    // Asynchronous reset during digit 2's slot
    wait_phase(2 * SLOT + 5);
    #1 rst_ni = 1'b0;
    #1 chk_off("async_rst");
    step(2);
    @(negedge clk_i); #2 rst_ni = 1'b1;
    step(FRAME + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
